// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the IF/ID boundary: opcode classes, reset PC+4 and register-field width.
// The uses_rs2 decode lives here so the forwarding unit can reuse the same source-operand rule.
package if_id_stage_pkg;

    localparam logic [5:0]  OP_RTYPE    = 6'h00;
    localparam logic [5:0]  OP_FRTYPE   = 6'h01;
    localparam logic [5:0]  OP_STORE_LO = 6'h28;
    localparam logic [5:0]  OP_STORE_HI = 6'h2F;

    localparam logic [31:0] DEFAULT_RESET_PC_PLUS_FOUR = 32'h0000_0004;
    localparam int          REG_FIELD_W                = 5;

    // R-types and stores read rs2; every other opcode only reads rs1.
    function automatic logic uses_rs2(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_FRTYPE) ||
               ((opcode >= OP_STORE_LO) && (opcode <= OP_STORE_HI));
    endfunction

endpackage

// File: rtl/if_id_stage_load_use_detect.sv
// Combinational load-use hazard compare between the IF/ID slot and the ID/EX load.
// Register 0 never produces a hazard since it is never really written.
module load_use_detect
    import if_id_stage_pkg::*;
#(
    parameter int REG_W = REG_FIELD_W
) (
    input  logic             i_id_valid,
    input  logic [5:0]       i_id_opcode,
    input  logic [REG_W-1:0] i_id_rs1,
    input  logic [REG_W-1:0] i_id_rs2,
    input  logic             i_ex_valid,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rd,
    output logic             o_hazard
);

    logic w_uses_rs2;
    logic w_rs1_match;
    logic w_rs2_match;
    logic w_load_pending;

    assign w_uses_rs2     = uses_rs2(i_id_opcode);
    assign w_rs1_match    = (i_ex_rd == i_id_rs1);
    assign w_rs2_match    = w_uses_rs2 && (i_ex_rd == i_id_rs2);
    assign w_load_pending = i_ex_valid && i_ex_mem_read && (i_ex_rd != '0);
    assign o_hazard       = i_id_valid && w_load_pending && (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with flush, external-stall and load-use stall control.
// Define IF_ID_HAZARD_STATS_EN to add saturating stall_cycles / flush_count counters.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC_PLUS_FOUR = DEFAULT_RESET_PC_PLUS_FOUR,
    parameter int          REG_W              = REG_FIELD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       if_opcode,
    input  logic [5:0]       if_function,
    input  logic [31:0]      if_pc_plus_four,
    input  logic [REG_W-1:0] if_rs1,
    input  logic [REG_W-1:0] if_rs2,
    input  logic [REG_W-1:0] if_rd,
    input  logic [15:0]      if_immediate,
    input  logic             if_valid,
    input  logic             flush,
    input  logic             ext_stall,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_valid,
    output logic [5:0]       id_opcode,
    output logic [5:0]       id_function,
    output logic [31:0]      id_pc_plus_four,
    output logic [REG_W-1:0] id_rs1,
    output logic [REG_W-1:0] id_rs2,
    output logic [REG_W-1:0] id_rd,
    output logic [15:0]      id_immediate,
    output logic             id_valid,
    output logic             pc_write_en,
    output logic             id_bubble,
    output logic             hazard_stall
`ifdef IF_ID_HAZARD_STATS_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_count
`endif
);

    logic [5:0]       r_opcode;
    logic [5:0]       r_function;
    logic [31:0]      r_pc_plus_four;
    logic [REG_W-1:0] r_rs1;
    logic [REG_W-1:0] r_rs2;
    logic [REG_W-1:0] r_rd;
    logic [15:0]      r_immediate;
    logic             r_valid;
    logic             w_hazard;

    load_use_detect #(
        .REG_W(REG_W)
    ) u_load_use_detect (
        .i_id_valid   (r_valid),
        .i_id_opcode  (r_opcode),
        .i_id_rs1     (r_rs1),
        .i_id_rs2     (r_rs2),
        .i_ex_valid   (ex_valid),
        .i_ex_mem_read(ex_mem_read),
        .i_ex_rd      (ex_rd),
        .o_hazard     (w_hazard)
    );

    // Flush only drops the valid bit; fields stay put so nothing downstream sees them change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_opcode       <= '0;
            r_function     <= '0;
            r_pc_plus_four <= RESET_PC_PLUS_FOUR;
            r_rs1          <= '0;
            r_rs2          <= '0;
            r_rd           <= '0;
            r_immediate    <= '0;
            r_valid        <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (!ext_stall && !w_hazard) begin
            r_opcode       <= if_opcode;
            r_function     <= if_function;
            r_pc_plus_four <= if_pc_plus_four;
            r_rs1          <= if_rs1;
            r_rs2          <= if_rs2;
            r_rd           <= if_rd;
            r_immediate    <= if_immediate;
            r_valid        <= if_valid;
        end
    end

    // An external stall freezes ID/EX too, so no bubble is injected while it is active.
    always_comb begin
        pc_write_en = 1'b1;
        id_bubble   = w_hazard || !r_valid;
        if (reset) begin
            pc_write_en = 1'b1;
            id_bubble   = 1'b1;
        end else if (flush) begin
            pc_write_en = 1'b1;
            id_bubble   = ext_stall ? 1'b0 : (w_hazard || !r_valid);
        end else if (ext_stall) begin
            pc_write_en = 1'b0;
            id_bubble   = 1'b0;
        end else if (w_hazard) begin
            pc_write_en = 1'b0;
        end
    end

    assign id_opcode       = r_opcode;
    assign id_function     = r_function;
    assign id_pc_plus_four = r_pc_plus_four;
    assign id_rs1          = r_rs1;
    assign id_rs2          = r_rs2;
    assign id_rd           = r_rd;
    assign id_immediate    = r_immediate;
    assign id_valid        = r_valid;
    assign hazard_stall    = w_hazard;

`ifdef IF_ID_HAZARD_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    // Only hazard cycles that actually cost a fetch slot are counted as stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
            if (w_hazard && !ext_stall && !flush && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule
